alu_op_sequencer: RTL and testbench

Upstream issue stage for the 2-bit ALU mux. Accepts operation requests (operands plus opcode) over a valid/ready handshake and buffers them in a small FIFO. Drives the ALU's A/B/S inputs from the FIFO head, registers the ALU's 4-bit result, and presents it downstream with its opcode over a second valid/ready handshake. Order is preserved; one operation per cycle sustained.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_op_sequencer_sync_fifo.sv | 74 +++++++
 rtl/alu_op_sequencer.sv | 104 ++++++++++
 tb/tb_alu_op_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, field widths
// and the packed request record held in the operand queue.
package alu_pkg;

    localparam int OPND_W = 2;
    localparam int RES_W  = 4;
    localparam int REQ_W  = 3 * OPND_W;

    localparam logic [1:0] OP_PRIME = 2'b00;
    localparam logic [1:0] OP_NAND  = 2'b01;
    localparam logic [1:0] OP_SUM   = 2'b10;
    localparam logic [1:0] OP_MULT  = 2'b11;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [1:0]        op;
    } req_t;

    function automatic req_t make_req(input logic [OPND_W-1:0] a,
                                      input logic [OPND_W-1:0] b,
                                      input logic [1:0]        op);
        req_t r;
        r.a  = a;
        r.b  = b;
        r.op = op;
        return r;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_sync_fifo.sv
// Synchronous FIFO with occupancy count; head data is read straight from the
// registered storage so the read side has no input-to-output path.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == (AW+1)'(0));
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next-state for storage, pointers (power-of-two wrap) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 2-bit ALU: queues requests, drives the ALU from the
// queue head and captures the result into a registered output handshake.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPND_W-1:0]        in_a,
    input  logic [OPND_W-1:0]        in_b,
    input  logic [1:0]               in_op,
    output logic [OPND_W-1:0]        alu_a,
    output logic [OPND_W-1:0]        alu_b,
    output logic [1:0]               alu_s,
    input  logic [RES_W-1:0]         alu_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_result,
    output logic [1:0]               out_op,
    output logic [$clog2(DEPTH):0]   count
);
    logic             push_s, fire_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [REQ_W-1:0] fifo_rdata_s;
    req_t             head_s;

    logic             out_valid_q, out_valid_d;
    logic [RES_W-1:0] out_result_q, out_result_d;
    logic [1:0]       out_op_q, out_op_d;

    // in_ready deliberately ignores out_ready: a full queue refuses even on a pop cycle.
    assign in_ready = !rst && !fifo_full_s;
    assign push_s   = in_valid && in_ready;
    assign fire_s   = !fifo_empty_s && (!out_valid_q || out_ready);
    assign head_s   = req_t'(fifo_rdata_s);

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (fire_s),
        .wdata (make_req(in_a, in_b, in_op)),
        .rdata (fifo_rdata_s),
        .count (count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // ALU operands come from the head entry, parked at zero when the queue is empty.
    always_comb begin
        alu_a = 2'b00;
        alu_b = 2'b00;
        alu_s = 2'b00;
        if (!fifo_empty_s) begin
            alu_a = head_s.a;
            alu_b = head_s.b;
            alu_s = head_s.op;
        end else begin
            alu_a = 2'b00;
            alu_b = 2'b00;
            alu_s = 2'b00;
        end
    end

    // Result register: capture on fire, drop valid on a bare accept, else hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        if (fire_s) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_o;
            out_op_d     = head_s.op;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result register flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 4'h0;
            out_op_q     <= 2'b00;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_op     = out_op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_a = 2'b00, in_b = 2'b00, in_op = 2'b00;
    logic [1:0]    alu_a, alu_b, alu_s;
    logic [3:0]    alu_o;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    out_result;
    logic [1:0]    out_op;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [5:0] sb_q[$];
    bit  mon_cnt = 1'b0;
    bit  consec  = 1'b0;
    int  last_cyc = -10;

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_o(alu_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural ALU: prime test on {a,b}, 2-bit NAND, sum, product.
    always_comb begin
        case (alu_s)
            2'b00: begin
                case ({alu_a, alu_b})
                    4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: alu_o = 4'd1;
                    default: alu_o = 4'd0;
                endcase
            end
            2'b01:   alu_o = {2'b00, ~(alu_a & alu_b)};
            2'b10:   alu_o = {2'b00, alu_a} + {2'b00, alu_b};
            default: alu_o = {2'b00, alu_a} * {2'b00, alu_b};
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drives one request and waits (bounded) for it to be accepted.
    task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                        input logic [3:0] exp, output bit ok);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                sb_q.push_back({op, exp});
                ok = 1'b1;
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got no accept expected accept (op=%0d)", op);
        end
    endtask

    // Monitor: pops the scoreboard on every downstream handshake.
    always @(negedge clk) begin
        logic [5:0] e;
        if (!consec) last_cyc = -10;
        if (mon_cnt) chk("count_le1", 32'(count <= CW'(1)), 32'd1);
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_out: got result %0d op %0d expected none", out_result, out_op);
            end else begin
                e = sb_q.pop_front();
                chk("out_result", 32'(out_result), 32'(e[3:0]));
                chk("out_op", 32'(out_op), 32'(e[5:4]));
            end
            if (consec && last_cyc >= 0) chk("consecutive", cyc, last_cyc + 1);
            if (consec) last_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, ok6;
        int p1, acc_cyc;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single SUM 3+2 latency
        @(posedge clk); #1;
        send(2'd3, 2'd2, OP_SUM, 4'd5, ok);
        @(negedge clk);
        chk("lat_alu_s", 32'(alu_s), 32'd2);
        chk("lat_alu_a", 32'(alu_a), 32'd3);
        chk("lat_alu_b", 32'(alu_b), 32'd2);
        chk("lat_valid_k1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid_k2", 32'(out_valid), 32'd1);
        chk("lat_result", 32'(out_result), 32'd5);
        chk("lat_op", 32'(out_op), 32'd2);
        @(posedge clk); #1;

        // Back-to-back MULT stream
        mon_cnt = 1'b1; consec = 1'b1;
        send(2'd3, 2'd3, OP_MULT, 4'd9, ok);
        send(2'd2, 2'd3, OP_MULT, 4'd6, ok);
        send(2'd1, 2'd3, OP_MULT, 4'd3, ok);
        send(2'd0, 2'd3, OP_MULT, 4'd0, ok);
        repeat (4) @(posedge clk);
        #1 mon_cnt = 1'b0; consec = 1'b0;
        chk("stream_drained", sb_q.size(), 0);

        // Stall: fill FIFO plus result register
        out_ready = 1'b0;
        send(2'd1, 2'd1, OP_SUM,  4'd2, ok);
        send(2'd2, 2'd2, OP_MULT, 4'd4, ok);
        send(2'd3, 2'd1, OP_NAND, 4'd2, ok);
        send(2'd3, 2'd3, OP_SUM,  4'd6, ok);
        send(2'd2, 2'd1, OP_NAND, 4'd3, ok);
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_result", 32'(out_result), 32'd2);
        chk("full_op", 32'(out_op), 32'd2);
        @(posedge clk); #1;
        fork
            begin
                send(2'd3, 2'd2, OP_MULT, 4'd6, ok6);
                acc_cyc = cyc;
            end
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_result", 32'(out_result), 32'd2);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk);
                chk("pop_full_count", 32'(count), 32'd4);
                chk("pop_full_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk); #1 p1 = cyc;
                @(negedge clk);
                chk("after_pop_count", 32'(count), 32'd3);
                chk("after_pop_in_ready", 32'(in_ready), 32'd1);
            end
        join
        chk("sixth_accept_cycle", acc_cyc, p1 + 1);
        repeat (10) @(posedge clk);
        #1 chk("stall_drained", sb_q.size(), 0);

        // Reset mid-operation
        out_ready = 1'b0;
        send(2'd2, 2'd2, OP_SUM,  4'd4, ok);
        send(2'd3, 2'd1, OP_SUM,  4'd4, ok);
        send(2'd1, 2'd2, OP_MULT, 4'd2, ok);
        send(2'd0, 2'd0, OP_NAND, 4'd3, ok);
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        sb_q.delete();
        rst = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(2'd1, 2'd2, OP_SUM,   4'd3, ok);
        send(2'd2, 2'd3, OP_PRIME, 4'd1, ok);
        repeat (5) @(posedge clk);
        #1 chk("final_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
